// File: rtl/calc1_unit_if.sv
// calc1_unit_if: request and response buses for the four calculator ports
interface calc1_unit_if;
  logic [0:3]  req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in;
  logic [0:31] req1_data_in, req2_data_in, req3_data_in, req4_data_in;
  logic [1:0]  out_resp1, out_resp2, out_resp3, out_resp4;
  logic [0:31] out_data1, out_data2, out_data3, out_data4;
  modport master (
    output req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
    output req1_data_in, req2_data_in, req3_data_in, req4_data_in,
    input  out_resp1, out_resp2, out_resp3, out_resp4,
    input  out_data1, out_data2, out_data3, out_data4
  );
  modport slave (
    input  req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
    input  req1_data_in, req2_data_in, req3_data_in, req4_data_in,
    output out_resp1, out_resp2, out_resp3, out_resp4,
    output out_data1, out_data2, out_data3, out_data4
  );
endinterface

// File: rtl/calc1_unit.sv
// calc1_unit: four independent 32-bit add/sub/shift command pipelines
module calc1_unit (
  input logic         c_clk,
  input logic [1:7]   reset,
  calc1_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, OP2, EXEC} state_e;
  logic [0:3]  cmd_in [4];
  logic [0:31] din    [4];
  logic [1:0]  resp_o [4];
  logic [0:31] dout_o [4];
  logic        unused_rst;
  // only reset[1] is functional; the remaining bits are reserved
  assign unused_rst = ^reset[2:7];
  assign cmd_in[0] = bus.req1_cmd_in;
  assign cmd_in[1] = bus.req2_cmd_in;
  assign cmd_in[2] = bus.req3_cmd_in;
  assign cmd_in[3] = bus.req4_cmd_in;
  assign din[0] = bus.req1_data_in;
  assign din[1] = bus.req2_data_in;
  assign din[2] = bus.req3_data_in;
  assign din[3] = bus.req4_data_in;
  assign bus.out_resp1 = resp_o[0];
  assign bus.out_resp2 = resp_o[1];
  assign bus.out_resp3 = resp_o[2];
  assign bus.out_resp4 = resp_o[3];
  assign bus.out_data1 = dout_o[0];
  assign bus.out_data2 = dout_o[1];
  assign bus.out_data3 = dout_o[2];
  assign bus.out_data4 = dout_o[3];
  genvar p;
  generate
    for (p = 0; p < 4; p++) begin : g_port
      state_e      state_q, state_d;
      logic [0:3]  cmd_q, cmd_d;
      logic [0:31] op1_q, op1_d, op2_q, op2_d, dout_q, dout_d, diff;
      logic [1:0]  resp_q, resp_d;
      logic [32:0] sum;
      assign resp_o[p] = resp_q;
      assign dout_o[p] = dout_q;
      always_ff @(posedge c_clk) begin
        if (!reset[1]) begin
          state_q <= IDLE;
          cmd_q   <= '0;
          op1_q   <= '0;
          op2_q   <= '0;
          resp_q  <= '0;
          dout_q  <= '0;
        end else begin
          state_q <= state_d;
          cmd_q   <= cmd_d;
          op1_q   <= op1_d;
          op2_q   <= op2_d;
          resp_q  <= resp_d;
          dout_q  <= dout_d;
        end
      end
      // response defaults to zero so it is visible for exactly one cycle
      always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        resp_d  = '0;
        dout_d  = '0;
        sum     = {1'b0, op1_q} + {1'b0, op2_q};
        diff    = op1_q - op2_q;
        case (state_q)
          IDLE: if (cmd_in[p] != '0) begin
            cmd_d   = cmd_in[p];
            op1_d   = din[p];
            state_d = OP2;
          end
          OP2: begin
            op2_d   = din[p];
            state_d = EXEC;
          end
          EXEC: begin
            state_d = IDLE;
            case (cmd_q)
              4'd1:    {resp_d, dout_d} = sum[32] ? {2'd2, 32'd0} : {2'd1, sum[31:0]};
              4'd2:    {resp_d, dout_d} = (op2_q > op1_q) ? {2'd2, 32'd0} : {2'd1, diff};
              4'd5:    {resp_d, dout_d} = {2'd1, op1_q << op2_q[27:31]};
              4'd6:    {resp_d, dout_d} = {2'd1, op1_q >> op2_q[27:31]};
              default: resp_d = 2'd2;
            endcase
          end
          default: state_d = IDLE;
        endcase
      end
    end
  endgenerate
endmodule

// File: tb/tb_calc1_unit.sv
// tb_calc1_unit: directed vectors with hand-computed results for calc1_unit
module tb_calc1_unit;
  logic        clk = 1'b0;
  logic [1:7]  reset = '0;
  logic [0:3]  cmd [4];
  logic [0:31] dat [4];
  logic [1:0]  rsp [4];
  logic [0:31] rd  [4];
  int n_chk = 0;
  int n_fail = 0;
  calc1_unit_if bus ();
  calc1_unit dut (.c_clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  assign bus.req1_cmd_in = cmd[0];
  assign bus.req2_cmd_in = cmd[1];
  assign bus.req3_cmd_in = cmd[2];
  assign bus.req4_cmd_in = cmd[3];
  assign bus.req1_data_in = dat[0];
  assign bus.req2_data_in = dat[1];
  assign bus.req3_data_in = dat[2];
  assign bus.req4_data_in = dat[3];
  assign rsp[0] = bus.out_resp1;
  assign rsp[1] = bus.out_resp2;
  assign rsp[2] = bus.out_resp3;
  assign rsp[3] = bus.out_resp4;
  assign rd[0] = bus.out_data1;
  assign rd[1] = bus.out_data2;
  assign rd[2] = bus.out_data3;
  assign rd[3] = bus.out_data4;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic all_idle(input string tag);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s resp%0d", tag, i + 1), rsp[i], 0);
      check($sformatf("%s data%0d", tag, i + 1), rd[i], 0);
    end
  endtask
  // called at a negedge; returns at the negedge after the response cleared
  task automatic run_op(input int p, input logic [0:3] c, input logic [0:31] a, input logic [0:31] b,
                        input logic [1:0] er, input logic [0:31] ed, input string tag);
    cmd[p] = c;
    dat[p] = a;
    @(negedge clk);
    dat[p] = b;
    @(negedge clk);
    cmd[p] = '0;
    dat[p] = $urandom;
    check({tag, " early"}, rsp[p], 0);
    @(negedge clk);
    check({tag, " resp"}, rsp[p], er);
    check({tag, " data"}, rd[p], ed);
    @(negedge clk);
    check({tag, " clr"}, rsp[p], 0);
  endtask
  initial begin
    for (int i = 0; i < 4; i++) begin
      cmd[i] = '0;
      dat[i] = '0;
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        cmd[i] = 4'($urandom);
        dat[i] = $urandom;
      end
      if (k > 0) all_idle("reset");
    end
    @(negedge clk);
    all_idle("reset end");
    for (int i = 0; i < 4; i++) cmd[i] = '0;
    reset = 7'b100_0000;
    run_op(0, 1, 32'h1, 32'h01FF_FFFF, 1, 32'h0200_0000, "add first");
    run_op(0, 1, 32'h1FFF_FFFF, 32'h1FFF_FFFF, 1, 32'h3FFF_FFFE, "add big");
    run_op(0, 1, 32'h0, 32'h0, 1, 32'h0, "add zero");
    run_op(0, 1, 32'hFFFF_FFFF, 32'h1, 2, 32'h0, "add ovf");
    for (int k = 0; k < 31; k++)
      run_op(0, 1, 32'h1 << k, 32'h0, 1, 32'h1 << k, $sformatf("walk%0d", k));
    run_op(0, 2, 32'h0F, 32'h01, 1, 32'h0E, "sub");
    run_op(0, 2, 32'h01, 32'h0F, 2, 32'h0, "sub unf");
    run_op(0, 2, 32'h5, 32'h5, 1, 32'h0, "sub eq");
    run_op(0, 5, 32'h1, 32'd31, 1, 32'h8000_0000, "shl31");
    run_op(0, 6, 32'h8000_0000, 32'd31, 1, 32'h1, "shr31");
    run_op(0, 5, 32'hFFFF_FFFF, 32'h20, 1, 32'hFFFF_FFFF, "shl32");
    run_op(1, 6, 32'hF000_0000, 32'hFFFF_FFE4, 1, 32'h0F00_0000, "shr hi");
    run_op(0, 3, 32'h1, 32'h1, 2, 32'h0, "inv3");
    run_op(0, 4, 32'h1, 32'h1, 2, 32'h0, "inv4");
    run_op(0, 15, 32'h1, 32'h1, 2, 32'h0, "inv15");
    for (int k = 0; k < 4; k++) begin
      dat[0] = $urandom;
      @(negedge clk);
      all_idle("noop");
    end
    cmd[0] = 1; dat[0] = 2;
    cmd[1] = 2; dat[1] = 3;
    cmd[2] = 5; dat[2] = 1;
    cmd[3] = 9; dat[3] = 1;
    @(negedge clk);
    dat[0] = 3; dat[1] = 7; dat[2] = 4; dat[3] = 1;
    for (int i = 0; i < 4; i++) cmd[i] = '0;
    @(negedge clk);
    all_idle("conc early");
    @(negedge clk);
    check("conc resp1", rsp[0], 1); check("conc data1", rd[0], 5);
    check("conc resp2", rsp[1], 2); check("conc data2", rd[1], 0);
    check("conc resp3", rsp[2], 1); check("conc data3", rd[2], 32'h10);
    check("conc resp4", rsp[3], 2); check("conc data4", rd[3], 0);
    @(negedge clk);
    all_idle("conc clr");
    cmd[0] = 1; dat[0] = 7;
    @(negedge clk);
    cmd[0] = '0; dat[0] = 8;
    reset = 7'b000_0000;
    @(negedge clk);
    reset = 7'b111_1111;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      all_idle("abort");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
